// File: rtl/i2c_led_master.sv
// i2c_led_master: write-only I2C controller (START, addr+W, data bytes with ACK check, STOP).
// Optional macro I2C_STRETCH_EN: hold the SCL-high phase while a target stretches SCL low.
module i2c_led_master #(
  parameter int QUARTER = 62,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [6:0] addr_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_DATA, S_ACK, S_LOAD, S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] qcnt;
  logic [1:0]       qph;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             last_byte, in_addr, ack_nack;
  logic             hold, tick, bit_end, accept, load_byte;
  logic             scl_nx, sda_nx;

`ifdef I2C_STRETCH_EN
  // SCL is released during q1; wait there until the bus actually reads high.
  assign hold = (qph == 2'd1) && !scl_i &&
                (state == S_ADDR || state == S_DATA || state == S_ACK || state == S_STOP);
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold = 1'b0;
`endif

  assign tick      = !hold && (qcnt == CNT_W'(QUARTER - 1));
  assign bit_end   = tick && (qph == 2'd3);
  assign accept    = (state == S_IDLE) && cmd_valid_i;
  assign load_byte = (state == S_LOAD) && data_valid_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      qph     <= '0;
      bitcnt  <= '0;
      in_addr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE || state == S_LOAD || state_nx != state || tick)
        qcnt <= '0;
      else if (!hold)
        qcnt <= qcnt + CNT_W'(1);
      if (state_nx != state) qph <= '0;
      else if (tick)         qph <= qph + 2'd1;
      if (state_nx != state) bitcnt <= '0;
      else if (bit_end)      bitcnt <= bitcnt + 3'd1;
      if (accept)         in_addr <= 1'b1;
      else if (load_byte) in_addr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      shreg <= {addr_i, 1'b0};
    else if (load_byte)
      shreg <= data_i;
    else if ((state == S_ADDR || state == S_DATA) && bit_end)
      shreg <= {shreg[6:0], 1'b0};
    if (load_byte)
      last_byte <= data_last_i;
    // ACK bit is sampled on the last clk of its second SCL-high quarter.
    if (state == S_ACK && tick && qph == 2'd2)
      ack_nack <= sda_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:         if (cmd_valid_i) state_nx = S_START;
      S_START:        if (tick && qph == 2'd1) state_nx = S_ADDR;
      S_ADDR, S_DATA: if (bit_end && bitcnt == 3'd7) state_nx = S_ACK;
      S_ACK: begin
        if (bit_end) begin
          if (ack_nack || (!in_addr && last_byte)) state_nx = S_STOP;
          else                                     state_nx = S_LOAD;
        end
      end
      S_LOAD:         if (data_valid_i) state_nx = S_DATA;
      S_STOP:         if (tick && qph == 2'd2) state_nx = S_IDLE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    scl_nx = 1'b1;
    sda_nx = 1'b1;
    case (state)
      S_START: begin
        scl_nx = (qph == 2'd0);
        sda_nx = 1'b0;
      end
      S_ADDR, S_DATA: begin
        scl_nx = qph[0] ^ qph[1];
        sda_nx = shreg[7];
      end
      S_ACK:  scl_nx = qph[0] ^ qph[1];
      S_LOAD: scl_nx = 1'b0;
      S_STOP: begin
        scl_nx = (qph != 2'd0);
        sda_nx = (qph == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_o        <= 1'b1;
      sda_o        <= 1'b1;
      cmd_ready_o  <= 1'b1;
      data_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      nack_o       <= 1'b0;
    end else begin
      scl_o        <= scl_nx;
      sda_o        <= sda_nx;
      cmd_ready_o  <= (state_nx == S_IDLE);
      busy_o       <= (state_nx != S_IDLE);
      data_ready_o <= load_byte;
      done_o       <= (state == S_STOP) && (state_nx == S_IDLE);
      if (accept)
        nack_o <= 1'b0;
      else if (state == S_ACK && bit_end && ack_nack)
        nack_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_led_master.sv
// Bench for i2c_led_master: behavioural I2C target, transaction table and byte scoreboard.
`timescale 1ns/1ps
module tb_i2c_led_master;
  localparam int QUARTER = 4;
  localparam int CNT_W   = 3;
  localparam int NONE    = 15;
`ifdef I2C_STRETCH_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_o, sda_o, scl_i, sda_i;
  logic [6:0] addr_i = '0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] data_i = '0;
  logic       data_valid_i = 1'b0;
  logic       data_last_i = 1'b0;
  logic       data_ready_o, busy_o, done_o, nack_o;
  logic       scl_pull = 1'b1;
  logic       sda_pull = 1'b1;

  assign scl_i = scl_o & scl_pull;
  assign sda_i = sda_o & sda_pull;

  always #5 clk = ~clk;

  i2c_led_master #(.QUARTER(QUARTER), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .scl_i(scl_i), .scl_o(scl_o), .sda_i(sda_i), .sda_o(sda_o),
    .addr_i(addr_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o)
  );

  typedef struct {
    logic [6:0]      addr;
    int              nbytes;
    logic [2:0][7:0] bytes;
    int              nack;   // byte index the target NACKs (0 = address), NONE = ack all
  } vec_t;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Target model: decodes bytes on SCL rise, drives ACK between the 8th and 9th SCL falls.
  int bitpos = 0, byte_idx = 0, nack_at = NONE;
  int starts = 0, stops = 0, rise_cnt = 0, ack_slots = 0;
  logic [7:0] shift_b = '0;
  logic scl_prev = 1'b1, sda_prev = 1'b1;
  always @(scl_i or sda_i) begin
    if (scl_i && scl_prev && sda_prev && !sda_i) begin
      starts++; bitpos = 0; byte_idx = 0;
    end else if (scl_i && scl_prev && !sda_prev && sda_i) begin
      stops++;
    end else if (scl_i && !scl_prev) begin
      rise_cnt++;
      if (bitpos < 8) begin
        shift_b = {shift_b[6:0], sda_i};
        bitpos++;
        if (bitpos == 8) got_q.push_back(shift_b);
      end else begin
        bitpos = 0; byte_idx++; ack_slots++;
      end
    end else if (!scl_i && scl_prev) begin
      sda_pull = !(bitpos == 8 && byte_idx != nack_at);
    end
    scl_prev = scl_i;
    sda_prev = sda_i;
  end

  int ready_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (data_ready_o) ready_cnt++;
    if (done_o)       done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] a, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input int nk);
    vec_t v;
    v.addr = a; v.nbytes = n; v.bytes = {b2, b1, b0}; v.nack = nk;
    return v;
  endfunction

  task automatic compare_bytes(input string tag);
    check({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, " byte"}, got_q[i], exp_q[i]);
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (busy_o && guard < 5000) begin @(negedge clk); guard++; end
    check({tag, " finishes"}, busy_o, 0);
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int rc0, dc0, st0, guard, exp_ready;
    exp_q.delete(); got_q.delete();
    nack_at = v.nack;
    rc0 = ready_cnt; dc0 = done_cnt; st0 = stops;
    exp_ready = (v.nack == NONE) ? v.nbytes : v.nack;
    check({tag, " cmd_ready idle"}, cmd_ready_o, 1);
    addr_i = v.addr; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    exp_q.push_back({v.addr, 1'b0});
    check({tag, " busy after accept"}, busy_o, 1);
    check({tag, " nack cleared"}, nack_o, 0);
    for (int i = 0; i < v.nbytes; i++) begin
      data_i = v.bytes[i]; data_last_i = (i == v.nbytes - 1); data_valid_i = 1'b1;
      guard = 0;
      while (!data_ready_o && busy_o && guard < 5000) begin @(negedge clk); guard++; end
      if (!data_ready_o) break;
      exp_q.push_back(v.bytes[i]);
      @(negedge clk);
    end
    data_valid_i = 1'b0; data_last_i = 1'b0;
    wait_idle(tag);
    check({tag, " ready pulses"}, ready_cnt - rc0, exp_ready);
    check({tag, " done pulses"}, done_cnt - dc0, 1);
    check({tag, " stop count"}, stops - st0, 1);
    check({tag, " nack_o"}, nack_o, (v.nack != NONE));
    check({tag, " cmd_ready after"}, cmd_ready_o, 1);
    compare_bytes(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int guard, bad, hw, a0, r0, rc0, dc0, st0;
    tbl[0] = mk(7'h4A, 3, 8'hAB, 8'h36, 8'h84, NONE);
    tbl[1] = mk(7'h4A, 3, 8'hAB, 8'h36, 8'h84, 0);
    tbl[2] = mk(7'h7F, 1, 8'h00, 8'h00, 8'h00, NONE);
    tbl[3] = mk(7'h00, 2, 8'hFF, 8'h5A, 8'h00, NONE);
    tbl[4] = mk(7'h15, 3, 8'h81, 8'h7E, 8'hC3, 2);
    tbl[5] = mk(7'h55, 2, 8'h80, 8'h01, 8'h00, 1);

    // Reset held with a pending command
    cmd_valid_i = 1'b1; addr_i = 7'h4A; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset scl_o", scl_o, 1);
      check("reset sda_o", sda_o, 1);
      check("reset busy_o", busy_o, 0);
      check("reset cmd_ready_o", cmd_ready_o, 1);
    end
    cmd_valid_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("no accept in reset", busy_o, 0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Unbounded stall in LOAD after the address ACK
    exp_q.delete(); got_q.delete(); nack_at = NONE;
    a0 = ack_slots; rc0 = ready_cnt;
    addr_i = 7'h4A; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    guard = 0;
    while (ack_slots == a0 && guard < 5000) begin @(negedge clk); guard++; end
    check("stall addr ack seen", ack_slots - a0, 1);
    guard = 0;
    while (scl_o && guard < 100) begin @(negedge clk); guard++; end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (scl_o !== 1'b0) bad++;
    end
    check("stall scl held low", bad, 0);
    check("stall no ready", ready_cnt - rc0, 0);
    data_i = 8'h3C; data_last_i = 1'b1; data_valid_i = 1'b1;
    guard = 0;
    while (!data_ready_o && guard < 100) begin @(negedge clk); guard++; end
    check("stall byte accepted", data_ready_o, 1);
    @(negedge clk);
    data_valid_i = 1'b0; data_last_i = 1'b0;
    guard = 0;
    while (!scl_o && guard < 100) begin @(negedge clk); guard++; end
    hw = 0;
    while (scl_o === 1'b1 && hw < 1000) begin hw++; @(negedge clk); end
    check("stall scl high width", hw, 2 * QUARTER + EXTRA);
    wait_idle("stall");
    check("stall got size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("stall addr byte", got_q[0], 8'h94);
      check("stall data byte", got_q[1], 8'h3C);
    end

    // Reset in the middle of the second data bit
    exp_q.delete(); got_q.delete(); nack_at = NONE;
    dc0 = done_cnt; st0 = stops;
    addr_i = 7'h2D; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    data_i = 8'hC3; data_last_i = 1'b1; data_valid_i = 1'b1;
    guard = 0;
    while (!data_ready_o && guard < 5000) begin @(negedge clk); guard++; end
    check("abort byte accepted", data_ready_o, 1);
    @(negedge clk);
    data_valid_i = 1'b0; data_last_i = 1'b0;
    r0 = rise_cnt;
    guard = 0;
    while (rise_cnt < r0 + 2 && guard < 1000) begin @(negedge clk); guard++; end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort scl_o", scl_o, 1);
    check("abort sda_o", sda_o, 1);
    check("abort busy_o", busy_o, 0);
    check("abort cmd_ready_o", cmd_ready_o, 1);
    repeat (20) @(negedge clk);
    check("abort no done", done_cnt - dc0, 0);
    check("abort no stop", stops - st0, 0);
    run_txn(tbl[2], "post-abort");

`ifdef I2C_STRETCH_EN
    // Target stretches SCL low across q1 of data bit 3
    exp_q.delete(); got_q.delete(); nack_at = NONE;
    addr_i = 7'h4A; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    data_i = 8'hA5; data_last_i = 1'b1; data_valid_i = 1'b1;
    guard = 0;
    while (!data_ready_o && guard < 5000) begin @(negedge clk); guard++; end
    @(negedge clk);
    data_valid_i = 1'b0; data_last_i = 1'b0;
    r0 = rise_cnt;
    guard = 0;
    while (rise_cnt < r0 + 2 && guard < 1000) begin @(negedge clk); guard++; end
    guard = 0;
    while (scl_i && guard < 100) begin @(negedge clk); guard++; end
    scl_pull = 1'b0;
    repeat (500) @(negedge clk);
    check("stretch dut releases scl", scl_o, 1);
    scl_pull = 1'b1;
    hw = 0;
    while (scl_i === 1'b1 && hw < 1000) begin hw++; @(negedge clk); end
    check("stretch high width ok", (hw >= 2 * QUARTER) && (hw <= 2 * QUARTER + 2), 1);
    wait_idle("stretch");
    check("stretch got size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("stretch addr byte", got_q[0], 8'h94);
      check("stretch data byte", got_q[1], 8'hA5);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
